// File: rtl/uart_regbank_pkg.sv
// Shared constants and types for the UART register bank.
package uart_regbank_pkg;

  // Register slot addresses (low two address bits).
  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_INTMASK = 2'd1;
  localparam logic [1:0] ADDR_DATA    = 2'd2;
  localparam logic [1:0] ADDR_BAUDDIV = 2'd3;

  // STATUS bit positions.
  localparam int ST_RX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_OVF   = 3;

  // Decoded kind of the bus access presented this cycle.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2,
    ACC_ERR  = 2'd3
  } access_t;

endpackage

// File: rtl/uart_regbank_hold_buf.sv
// Single-entry holding buffer.
// Handshake: a push is accepted when the buffer is empty or is popped in the
// same cycle; otherwise the pushed word is dropped and 'drop' pulses for that
// cycle. A pop on an empty buffer has no effect.
module hold_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout,
  output logic         drop
);

  logic accept;

  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // Occupancy and data: a same-cycle push+pop reloads, a lone pop empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (accept) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_regbank.sv
// Register bank and bus slave for the serial peripheral: STATUS, INTMASK,
// DATA (TX/RX holding buffers) and BAUDDIV, with registered ack/err/rdata.
module uart_regbank
  import uart_regbank_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int DIV_RESET = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] baud_div,
  output logic              irq
);

  access_t           kind;
  logic [1:0]        slot;
  logic              addr_hi;
  logic              wr_status, wr_data, rd_data;
  logic              rx_full, rx_drop, tx_drop;
  logic [DATA_W-1:0] rx_dout;
  logic              rx_ovr, tx_ovf;
  logic [3:0]        intmask;
  logic [3:0]        status;
  logic [DATA_W-1:0] rd_val;

  assign slot    = addr[1:0];
  assign addr_hi = (ADDR_W > 2) ? |(addr >> 2) : 1'b0;

  // Classify the access; strobe conflicts and out-of-map slots are errors.
  always_comb begin
    kind = ACC_NONE;
    if (cs && (we || re)) begin
      if ((we && re) || addr_hi) kind = ACC_ERR;
      else if (we)               kind = ACC_WR;
      else                       kind = ACC_RD;
    end
  end

  assign wr_status = (kind == ACC_WR) && (slot == ADDR_STATUS);
  assign wr_data   = (kind == ACC_WR) && (slot == ADDR_DATA);
  assign rd_data   = (kind == ACC_RD) && (slot == ADDR_DATA);

  hold_buf #(.W(DATA_W)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_data),
    .pop   (tx_ready),
    .din   (wdata),
    .full  (tx_valid),
    .dout  (tx_data),
    .drop  (tx_drop)
  );

  hold_buf #(.W(DATA_W)) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (rd_data),
    .din   (rx_data),
    .full  (rx_full),
    .dout  (rx_dout),
    .drop  (rx_drop)
  );

  assign status = {tx_ovf, rx_ovr, ~tx_valid, rx_full};

  // Read mux over pre-update register state; empty RX reads as zero.
  always_comb begin
    rd_val = '0;
    case (slot)
      ADDR_STATUS:  rd_val = DATA_W'(status);
      ADDR_INTMASK: rd_val = DATA_W'(intmask);
      ADDR_DATA:    rd_val = rx_full ? rx_dout : '0;
      default:      rd_val = baud_div;
    endcase
  end

  // Bus response: ack/err one cycle after the access, rdata only for reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= (kind != ACC_NONE);
      err   <= (kind == ACC_ERR);
      rdata <= (kind == ACC_RD) ? rd_val : '0;
    end
  end

  // Writable registers; sticky flags set on drop, W1C, set wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intmask  <= 4'h0;
      baud_div <= DATA_W'(DIV_RESET);
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      if ((kind == ACC_WR) && (slot == ADDR_INTMASK)) intmask <= wdata[3:0];
      if ((kind == ACC_WR) && (slot == ADDR_BAUDDIV)) baud_div <= wdata;
      rx_ovr <= rx_drop | (rx_ovr & ~(wr_status & wdata[ST_RX_OVR]));
      tx_ovf <= tx_drop | (tx_ovf & ~(wr_status & wdata[ST_TX_OVF]));
    end
  end

  // Interrupt is a registered view of the masked status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(status & intmask);
  end

endmodule

// File: tb/tb_uart_regbank.sv
// Directed self-checking bench for uart_regbank (default build plus an
// ADDR_W=3 build for out-of-map address errors).
module tb_uart_regbank;
  import uart_regbank_pkg::*;

  logic       clk, rst_n;
  logic       cs, we, re, tx_ready, rx_valid;
  logic [1:0] addr;
  logic [7:0] wdata, rx_data;
  logic [7:0] rdata, tx_data, baud_div;
  logic       ack, err, tx_valid, irq;

  logic       cs3;
  logic [2:0] addr3;
  logic [7:0] rdata3, tx_data3, baud_div3;
  logic       ack3, err3, tx_valid3, irq3;
  logic       zero_bit;
  logic [7:0] zero_byte;

  int tests, fails;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_regbank #(.DATA_W(8), .ADDR_W(2), .DIV_RESET(26)) u0 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .baud_div(baud_div), .irq(irq)
  );

  uart_regbank #(.DATA_W(8), .ADDR_W(3), .DIV_RESET(26)) u3 (
    .clk(clk), .rst_n(rst_n), .cs(cs3), .we(zero_bit), .re(cs3), .addr(addr3),
    .wdata(zero_byte), .rdata(rdata3), .ack(ack3), .err(err3), .tx_data(tx_data3),
    .tx_valid(tx_valid3), .tx_ready(zero_bit), .rx_data(zero_byte),
    .rx_valid(zero_bit), .baud_div(baud_div3), .irq(irq3)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus access driven at a falling edge; returns at the falling edge of
  // the ack cycle. Optional same-cycle tx_ready / rx_valid pulses.
  task automatic bus(input logic w, input logic r, input logic [1:0] a,
                     input logic [7:0] d, input logic txr = 1'b0,
                     input logic rxv = 1'b0, input logic [7:0] rxd = 8'h00);
    @(negedge clk);
    cs = 1'b1; we = w; re = r; addr = a; wdata = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; re = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    cs = 0; we = 0; re = 0; addr = 0; wdata = 0; tx_ready = 0;
    rx_valid = 0; rx_data = 0; cs3 = 0; addr3 = 0;
    zero_bit = 0; zero_byte = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_baud", baud_div, 26);
    rst_n = 1'b1;

    // BAUDDIV read / write
    bus(0, 1, ADDR_BAUDDIV, 0);
    check("baud_rd", rdata, 26);
    check("baud_rd_ack", ack, 1);
    check("baud_rd_err", err, 0);
    bus(1, 0, ADDR_BAUDDIV, 8'h55);
    check("baud_wr", baud_div, 8'h55);
    @(negedge clk);
    check("ack_single", ack, 0);

    // TX load, overflow, W1C
    bus(1, 0, ADDR_DATA, 8'hA1);
    check("tx_valid", tx_valid, 1);
    check("tx_data", tx_data, 8'hA1);
    bus(1, 0, ADDR_DATA, 8'hB2);
    check("tx_keep", tx_data, 8'hA1);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_ovf", rdata, 8'h08);
    bus(1, 0, ADDR_STATUS, 8'h08);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_w1c", rdata, 8'h00);

    // TX reload while draining, then drain
    bus(1, 0, ADDR_DATA, 8'hC3, 1'b1);
    check("tx_reload_v", tx_valid, 1);
    check("tx_reload_d", tx_data, 8'hC3);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_reload", rdata, 8'h00);
    @(negedge clk); tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    check("tx_drain", tx_valid, 0);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_empty", rdata, 8'h02);

    // RX overrun: first byte kept
    rx_pulse(8'h3C); exp_q.push_back(8'h3C);
    rx_pulse(8'h4D);
    bus(0, 1, ADDR_DATA, 0);
    exp_b = exp_q.pop_front();
    check("rx_first", rdata, exp_b);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_rx_ovr", rdata, 8'h06);
    bus(1, 0, ADDR_STATUS, 8'h04);
    bus(0, 1, ADDR_DATA, 0);
    check("rx_empty_rd", rdata, 8'h00);
    check("rx_empty_err", err, 0);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_ovr_clr", rdata, 8'h02);

    // INTMASK width and irq timing
    bus(1, 0, ADDR_INTMASK, 8'hFF);
    bus(0, 1, ADDR_INTMASK, 0);
    check("imask_wide", rdata, 8'h0F);
    bus(1, 0, ADDR_INTMASK, 8'h01);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk); rx_valid = 1'b0;
    check("irq_t1", irq, 0);
    @(negedge clk);
    check("irq_t2", irq, 1);
    bus(0, 1, ADDR_DATA, 0);
    exp_b = exp_q.pop_front();
    check("irq_rd_data", rdata, exp_b);
    check("irq_rd_t1", irq, 1);
    @(negedge clk);
    check("irq_rd_t2", irq, 0);

    // Strobe conflict error
    bus(1, 1, ADDR_INTMASK, 8'h0E);
    check("conf_ack", ack, 1);
    check("conf_err", err, 1);
    check("conf_rdata", rdata, 0);
    bus(0, 1, ADDR_INTMASK, 0);
    check("conf_noeff", rdata, 8'h01);
    check("conf_err_gone", err, 0);

    // Out-of-map address on the ADDR_W=3 build
    @(negedge clk); cs3 = 1'b1; addr3 = 3'd5;
    @(negedge clk); cs3 = 1'b0;
    check("a5_ack", ack3, 1);
    check("a5_err", err3, 1);
    check("a5_rdata", rdata3, 0);
    @(negedge clk); cs3 = 1'b1; addr3 = 3'd3;
    @(negedge clk); cs3 = 1'b0;
    check("a3_rdata", rdata3, 26);
    check("a3_err", err3, 0);

    // RX capture coinciding with a DATA read on a full buffer
    rx_pulse(8'h11);
    bus(0, 1, ADDR_DATA, 0, 1'b0, 1'b1, 8'h22);
    check("rx_pop_old", rdata, 8'h11);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_pop_push", rdata, 8'h03);
    bus(0, 1, ADDR_DATA, 0);
    check("rx_pop_new", rdata, 8'h22);

    // Overrun set colliding with its W1C: set wins, contents kept
    rx_pulse(8'h33);
    bus(1, 0, ADDR_STATUS, 8'h04, 1'b0, 1'b1, 8'h44);
    bus(0, 1, ADDR_STATUS, 0);
    check("st_set_wins", rdata, 8'h07);
    bus(0, 1, ADDR_DATA, 0);
    check("rx_kept", rdata, 8'h33);

    // Reset in the middle of an access
    bus(1, 0, ADDR_DATA, 8'h99);
    @(negedge clk);
    cs = 1'b1; re = 1'b1; addr = ADDR_BAUDDIV;
    #2 rst_n = 1'b0;
    @(negedge clk);
    cs = 1'b0; re = 1'b0;
    check("mid_ack", ack, 0);
    check("mid_rdata", rdata, 0);
    check("mid_txv", tx_valid, 0);
    check("mid_baud", baud_div, 26);
    check("mid_irq", irq, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("mid_no_late_ack", ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_regbank.md
Name: uart_regbank

Overview:
- Parametrised register bank and bus slave for the serial peripheral.
- Replaces the bare chip-select address decoder with registered read/write access and per-access acknowledge.
- Holds the STATUS, INTMASK, DATA and BAUDDIV registers, with one-entry TX and RX holding buffers, sticky error flags and a maskable interrupt.
- Sits between the CPU-side bus and the serial TX/RX engines.

Parameters:
- DATA_W, 8, bus and register data width; must be at least 4.
- ADDR_W, 2, register address width; 2^ADDR_W decoded slots, minimum 2.
- DIV_RESET, 26, reset value of BAUDDIV.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select.
- we  in  1  write strobe, qualified by cs.
- re  in  1  read strobe, qualified by cs.
- addr  in  ADDR_W  register address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid in the ack cycle.
- ack  out  1  one-cycle access acknowledge.
- err  out  1  one-cycle error, coincident with ack.
- tx_data  out  DATA_W  byte to the transmitter.
- tx_valid  out  1  TX holding register full.
- tx_ready  in  1  transmitter accepts tx_data.
- rx_data  in  DATA_W  byte from the receiver.
- rx_valid  in  1  receiver presents a byte for one cycle; cannot be stalled.
- baud_div  out  DATA_W  current BAUDDIV value.
- irq  out  1  interrupt request.

Behaviour:
- Reset (async, rst_n low) clears all state:
  - rdata, ack, err, tx_data, tx_valid, irq, INTMASK, the RX buffer and the sticky flags all clear to 0.
  - baud_div resets to DIV_RESET.
  - Reset mid-access drops the access; no ack follows.
- Access definition: an access occurs in any cycle with cs=1 and (we|re)=1.
  - ack=1 in the following cycle, for exactly one cycle.
  - Back-to-back accesses every cycle are legal.
- Error accesses raise err with that ack, have no side effects and return rdata=0:
  - we=1 and re=1 together;
  - any address ≥ 4, when ADDR_W > 2.
- Register map: 0 STATUS, 1 INTMASK, 2 DATA, 3 BAUDDIV.
- STATUS bits (all bits above bit 3 read as 0):
  - bit0 rx_full, read-only;
  - bit1 tx_empty (= ~tx_valid), read-only;
  - bit2 rx_overrun, sticky, write-1-to-clear (W1C);
  - bit3 tx_overflow, sticky, W1C.
- INTMASK: read/write, bits [3:0] only; upper bits read as 0.
- BAUDDIV: read/write, full DATA_W width; baud_div tracks it with no extra delay.
- DATA write:
  - If the TX buffer is empty, or drains (tx_valid & tx_ready) in the same cycle, the byte is loaded and tx_valid=1 next cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
- DATA read:
  - Returns the RX byte, clears rx_full and frees the buffer.
  - If the buffer is empty, returns 0 with no error.
- RX capture: when rx_valid=1:
  - buffer empty, or popped by a DATA read in the same cycle → byte stored, rx_full=1;
  - otherwise → byte dropped, rx_overrun set, buffer contents kept.
- TX drain: when tx_valid & tx_ready, tx_valid clears next cycle unless reloaded in the same cycle.
- Set/clear collision: when a W1C and a set event for the same bit occur in the same cycle, set wins.
- irq is registered: irq = |(STATUS[3:0] & INTMASK[3:0]), evaluated on the register values one cycle before.
- Read data reflects register state before any same-cycle update.

Decomposition:
- Package uart_regbank_pkg holds:
  - address constants ADDR_STATUS=0, ADDR_INTMASK=1, ADDR_DATA=2, ADDR_BAUDDIV=3;
  - status bit indices ST_RX_FULL=0, ST_TX_EMPTY=1, ST_RX_OVR=2, ST_TX_OVF=3;
  - an enum for the decoded access kind (NONE, RD, WR, ERR).
- One sub-module, hold_buf: a single-entry valid/data buffer with push, pop, same-cycle push+pop and a drop flag. It is instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then read addr 3 → rdata=26, err=0. Write 0x55 to addr 3 → baud_div=0x55 in the ack cycle.
- Write DATA=0xA1 with tx_ready=0 → tx_valid=1, tx_data=0xA1. Write 0xB2 → STATUS reads 0x08; write STATUS=0x08 → reads 0x00.
- rx_valid with 0x3C, then with 0x4D before any read → DATA read returns 0x3C and STATUS reads 0x06 (rx_full clear after the pop).
- INTMASK=0x01, then RX byte arrives → irq=1 two cycles after rx_valid; DATA read → irq=0 two cycles after the read.
- cs=1, we=1, re=1 at addr 1 → ack=1, err=1, INTMASK unchanged. ADDR_W=3 build: read addr 5 → err=1, rdata=0.
- rx_valid and a DATA read in the same cycle with the buffer full → no overrun, new byte held. Assert rst_n mid-access → no ack, all outputs at reset values.
